prog_sequencer: RTL and testbench

- Upstream instruction source for the 4-bit microcode processor.
- Holds a small program memory loaded through a write port.
- On start, steps through memory, presenting each 8-bit instruction with a one-cycle load pulse followed by an execute window.
- Drives the processor's state, load and instr inputs directly; the data bus is not touched.

---
 rtl/prog_sequencer_if.sv | 60 ++++++
 rtl/prog_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_prog_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// prog_sequencer_if
//   Bundles the program-load port and the processor-facing outputs of
//   prog_sequencer.
//
//   Signals
//     wr_en / wr_addr / wr_data : program memory write port
//     start                     : begin a run from address 0
//     state / load / instr      : processor phase, load strobe, instruction
//     pc                        : address of the instruction being issued
//     busy / done               : run in progress / run finished (sticky)
//     step / paused             : single-step control, present only when
//                                 SEQ_SINGLE_STEP_EN is defined
//
//   Modports
//     master : drives the write port and start, observes the outputs
//     slave  : the sequencer itself
//
//   Build option: SEQ_SINGLE_STEP_EN adds step (to sequencer) and paused
//   (from sequencer).
// ---------------------------------------------------------------------------
interface prog_sequencer_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic          state;
    logic          load;
    logic [7:0]    instr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

`ifdef SEQ_SINGLE_STEP_EN
    logic          step;
    logic          paused;

    modport master (
        output wr_en, wr_addr, wr_data, start, step,
        input  state, load, instr, pc, busy, done, paused
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, step,
        output state, load, instr, pc, busy, done, paused
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  state, load, instr, pc, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output state, load, instr, pc, busy, done
    );
`endif
endinterface

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//   Instruction source for the 4-bit microcode processor. A small program
//   memory is loaded through a write port; on start the sequencer walks the
//   memory from address 0, presenting each instruction with a one-cycle load
//   pulse followed by an EXEC_CYCLES-long execute window (state=1). A word
//   equal to HALT_OP, or running off the last address, ends the run.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset (memory contents are kept)
//     bus  : prog_sequencer_if.slave
//              in : wr_en, wr_addr, wr_data, start [, step]
//              out: state, load, instr, pc, busy, done [, paused]
//
//   Parameters
//     DEPTH       : program words (DEPTH = 2**AW)
//     AW          : address width
//     EXEC_CYCLES : execute window length, 1..255
//     HALT_OP     : opcode that ends a run; never issued
//
//   Build option
//     SEQ_SINGLE_STEP_EN : after every execute window the sequencer parks in
//     PAUSE (paused=1) until a step pulse lets it advance.
//
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module prog_sequencer #(
    parameter int         DEPTH       = 16,
    parameter int         AW          = 4,
    parameter int         EXEC_CYCLES = 4,
    parameter logic [7:0] HALT_OP     = 8'hFF
) (
    input  logic           clk,
    input  logic           rst,
    prog_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_DONE
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } fsm_t;

    localparam logic [7:0]    EXEC_LAST = 8'(EXEC_CYCLES - 1);
    localparam logic [AW-1:0] PC_LAST   = AW'(DEPTH - 1);

    fsm_t          fsm_reg, fsm_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [7:0]    instr_reg, instr_next;
    logic          state_reg, state_next;
    logic          load_reg, load_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
`ifdef SEQ_SINGLE_STEP_EN
    logic          paused_reg, paused_next;
`endif

    // Set when the current instruction is finished and the sequencer should
    // either move to the next address or stop at the top of memory.
    logic          advance;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_data_reg;
    logic          wr_accept;

    assign wr_accept = bus.wr_en && !busy_reg;

    // -----------------------------------------------------------------------
    // Program memory: synchronous write, registered read.
    // The read address is the pc the FSM is about to hold, so the word is
    // already in rd_data_reg during the FETCH cycle. A write landing on the
    // same edge (e.g. together with start) is forwarded so FETCH sees it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (wr_accept && (bus.wr_addr == pc_next)) begin
            rd_data_reg <= bus.wr_data;
        end else begin
            rd_data_reg <= mem[pc_next];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        fsm_next    = fsm_reg;
        cnt_next    = cnt_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        state_next  = state_reg;
        load_next   = 1'b0;
        busy_next   = busy_reg;
        done_next   = done_reg;
`ifdef SEQ_SINGLE_STEP_EN
        paused_next = paused_reg;
`endif
        advance     = 1'b0;

        case (fsm_reg)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    fsm_next  = S_FETCH;
                    pc_next   = '0;
                    busy_next = 1'b1;
                    done_next = 1'b0;
                end
            end

            S_FETCH: begin
                if (rd_data_reg == HALT_OP) begin
                    // HALT is never issued: instr keeps its previous value.
                    fsm_next  = S_DONE;
                    busy_next = 1'b0;
                    done_next = 1'b1;
                end else begin
                    instr_next = rd_data_reg;
                    load_next  = 1'b1;
                    fsm_next   = S_LOAD;
                end
            end

            S_LOAD: begin
                fsm_next   = S_EXEC;
                state_next = 1'b1;
                cnt_next   = EXEC_LAST;
            end

            S_EXEC: begin
                if (cnt_reg == '0) begin
                    state_next = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
                    fsm_next    = S_PAUSE;
                    paused_next = 1'b1;
`else
                    advance     = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end

`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (bus.step) begin
                    paused_next = 1'b0;
                    advance     = 1'b1;
                end
            end
`endif

            default: begin
                fsm_next = S_IDLE;
            end
        endcase

        // The last address ends the run rather than wrapping to 0.
        if (advance) begin
            if (pc_reg == PC_LAST) begin
                fsm_next  = S_DONE;
                busy_next = 1'b0;
                done_next = 1'b1;
            end else begin
                pc_next  = pc_reg + 1'b1;
                fsm_next = S_FETCH;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg    <= S_IDLE;
            cnt_reg    <= '0;
            pc_reg     <= '0;
            instr_reg  <= '0;
            state_reg  <= 1'b0;
            load_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
            paused_reg <= 1'b0;
`endif
        end else begin
            fsm_reg    <= fsm_next;
            cnt_reg    <= cnt_next;
            pc_reg     <= pc_next;
            instr_reg  <= instr_next;
            state_reg  <= state_next;
            load_reg   <= load_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
`ifdef SEQ_SINGLE_STEP_EN
            paused_reg <= paused_next;
`endif
        end
    end

    assign bus.state  = state_reg;
    assign bus.load   = load_reg;
    assign bus.instr  = instr_reg;
    assign bus.pc     = pc_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
`ifdef SEQ_SINGLE_STEP_EN
    assign bus.paused = paused_reg;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
//   Scoreboard bench for prog_sequencer. The driver keeps a copy of the
//   program memory and, when a start is accepted, lists the instructions the
//   run must issue (cycle of the load pulse, instruction, address) and the
//   cycle/instr/pc at which done must rise. A monitor pops and compares those
//   whenever the DUT pulses load or raises done, and also checks every
//   execute window length and instr stability.
//
//   Cycle numbering: cyc counts rising edges; "cycle c" is the interval
//   after edge c-1, so the value seen at a falling edge is cycle cyc+1, and a
//   stimulus applied at that falling edge is sampled at edge cyc+1.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;
    localparam int         AW    = 4;
    localparam int         DEPTH = 16;
    localparam int         E     = 4;
    localparam logic [7:0] HALT  = 8'hFF;
`ifdef SEQ_SINGLE_STEP_EN
    localparam int         PER   = E + 3;   // FETCH, LOAD, EXEC x E, PAUSE
`else
    localparam int         PER   = E + 2;   // FETCH, LOAD, EXEC x E
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_sequencer_if #(.AW(AW)) sif ();

    prog_sequencer #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .EXEC_CYCLES(E),
        .HALT_OP    (HALT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

`ifdef SEQ_SINGLE_STEP_EN
    bit auto_step   = 1'b1;
    bit manual_step = 1'b0;
    // Outside the dedicated step test, release every pause after one cycle.
    assign sif.step = (auto_step && sif.paused) || manual_step;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         cyc;
        logic [7:0] instr;
        int         pc;
    } ev_t;

    ev_t        load_q[$];
    ev_t        done_q[$];
    logic [7:0] m_mem [DEPTH];
    bit         m_active = 1'b0;
    int         m_k      = 0;
    int         m_done   = 0;
    logic [7:0] m_instr  = 8'h00;

    // busy is high from the cycle after the start edge until done rises.
    function automatic bit m_busy(input int e);
        return m_active && (e >= m_k + 1) && (e <= m_done - 1);
    endfunction

    task automatic m_start(input int k);
        int  stop;
        bit  halted;
        if (m_busy(k)) return;
        m_active = 1'b1;
        m_k      = k;
        halted   = 1'b0;
        stop     = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_mem[i] == HALT) begin
                halted = 1'b1;
                stop   = i;
                break;
            end
            load_q.push_back('{k + 2 + i * PER, m_mem[i], i});
            m_instr = m_mem[i];
        end
        m_done = halted ? (k + 2 + stop * PER) : (k + 1 + DEPTH * PER);
        done_q.push_back('{m_done, m_instr, stop});
    endtask

    // ---------------- driver helpers (called at a falling edge) ----------------
    task automatic drive(input bit we, input int addr, input logic [7:0] data, input bit st);
        int e;
        e = cyc + 1;
        sif.wr_en   = we;
        sif.wr_addr = addr[AW-1:0];
        sif.wr_data = data;
        sif.start   = st;
        if (we && !m_busy(e)) m_mem[addr] = data;
        if (st) m_start(e);
        @(negedge clk);
        sif.wr_en = 1'b0;
        sif.start = 1'b0;
    endtask

    task automatic load_prog(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        drive(1'b1, 0, w0, 1'b0);
        drive(1'b1, 1, w1, 1'b0);
        drive(1'b1, 2, w2, 1'b0);
    endtask

    // Wait for the scoreboard to drain; optionally poke spurious writes and
    // starts while the model says the DUT is busy (both must be ignored).
    task automatic wait_drain(input string name, input int budget, input bit poke);
        int n;
        n = 0;
        while ((load_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            if (poke && m_busy(cyc + 1) && $urandom_range(0, 7) == 0)
                drive(1'b1, $urandom_range(0, DEPTH - 1), 8'($urandom), 1'($urandom_range(0, 1)));
            else
                @(negedge clk);
            n++;
        end
        chk({"drain_", name}, load_q.size() + done_q.size(), 0);
        load_q.delete();
        done_q.delete();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_state"}, sif.state, 0);
        chk({name, "_load"},  sif.load,  0);
        chk({name, "_instr"}, sif.instr, 8'h00);
        chk({name, "_pc"},    sif.pc,    0);
        chk({name, "_busy"},  sif.busy,  0);
        chk({name, "_done"},  sif.done,  0);
    endtask

    // ---------------- monitor ----------------
    int         state_run  = 0;
    logic       prev_done  = 1'b0;
    logic [7:0] last_instr = 8'h00;

    always @(negedge clk) begin
        ev_t ev;
        int  sc;
        sc = cyc + 1;
        if (rst) begin
            state_run = 0;
            prev_done = 1'b0;
        end else begin
            if (sif.load) begin
                chk("load_state_excl", sif.state, 0);
                if (load_q.size() == 0) begin
                    chk("load_expected", sif.load, 0);
                end else begin
                    ev = load_q.pop_front();
                    $display("load  cycle=%0d pc=%0d instr=%02h", sc, sif.pc, sif.instr);
                    chk("load_cycle", sc, ev.cyc);
                    chk("load_instr", sif.instr, ev.instr);
                    chk("load_pc", sif.pc, ev.pc);
                    last_instr = ev.instr;
                end
            end
            if (sif.state) begin
                state_run++;
                chk("exec_instr_stable", sif.instr, last_instr);
            end else if (state_run != 0) begin
                chk("exec_len", state_run, E);
                state_run = 0;
            end
            if (sif.done && !prev_done) begin
                if (done_q.size() == 0) begin
                    chk("done_expected", sif.done, 0);
                end else begin
                    ev = done_q.pop_front();
                    $display("done  cycle=%0d pc=%0d instr=%02h", sc, sif.pc, sif.instr);
                    chk("done_cycle", sc, ev.cyc);
                    chk("done_instr", sif.instr, ev.instr);
                    chk("done_pc", sif.pc, ev.pc);
                    chk("done_busy", sif.busy, 0);
                end
            end
            prev_done = sif.done;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int h;
        sif.wr_en   = 1'b0;
        sif.wr_addr = '0;
        sif.wr_data = 8'h00;
        sif.start   = 1'b0;

        // Reset, then idle with start low.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk_reset_outputs("idle");
        end

        // Basic run: 12, 34, HALT with random filler behind it.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 8'($urandom_range(0, 254)), 1'b0);
        load_prog(8'h12, 8'h34, HALT);
        k = cyc + 1;
        drive(1'b0, 0, 8'h00, 1'b1);
        @(negedge clk);                       // cycle k+2
        drive(1'b1, 1, 8'hAA, 1'b0);          // write while busy: rejected
        drive(1'b0, 0, 8'h00, 1'b1);          // start while busy: ignored
        wait_drain("basic", 200, 1'b0);

        // Restart from DONE: done drops on the start edge.
        drive(1'b0, 0, 8'h00, 1'b1);
        chk("restart_done_clear", sif.done, 0);
        chk("restart_busy", sif.busy, 1);
        chk("restart_pc", sif.pc, 0);
        wait_drain("restart", 200, 1'b0);

        // Full memory, no HALT: 16 issues, stops at pc 15.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 8'h01, 1'b0);
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_drain("full", 400, 1'b0);

        // Reset during the second EXEC cycle, then replay.
        load_prog(8'h12, 8'h34, HALT);
        k = cyc + 1;
        drive(1'b0, 0, 8'h00, 1'b1);
        while (cyc + 1 < k + 4) @(negedge clk);
        rst = 1'b1;
        load_q.delete();
        done_q.delete();
        m_active = 1'b0;
        m_instr  = 8'h00;
        @(negedge clk);
        chk_reset_outputs("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_drain("replay", 200, 1'b0);

        // Randomized programs with spurious traffic while busy.
        for (int it = 0; it < 8; it++) begin
            h = $urandom_range(0, DEPTH + 3);
            for (int i = 0; i < DEPTH; i++)
                drive(1'b1, i, (i == h) ? HALT : 8'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (it % 2 == 0)
                drive(1'b1, 0, 8'($urandom_range(0, 255)), 1'b1);   // write + start together
            else
                drive(1'b0, 0, 8'h00, 1'b1);
            wait_drain("random", 600, 1'b1);
        end

`ifdef SEQ_SINGLE_STEP_EN
        // Single step: hold in PAUSE until step, then FETCH pc+1.
        auto_step = 1'b0;
        load_prog(8'h12, 8'h34, HALT);
        k = cyc + 1;
        sif.start = 1'b1;
        load_q.push_back('{k + 2, 8'h12, 0});
        @(negedge clk);
        sif.start = 1'b0;
        while (cyc + 1 < k + 7) @(negedge clk);
        repeat (20) begin
            chk("pause_paused", sif.paused, 1);
            chk("pause_pc", sif.pc, 0);
            chk("pause_state", sif.state, 0);
            @(negedge clk);
        end
        k = cyc + 1;
        manual_step = 1'b1;
        load_q.push_back('{k + 2, 8'h34, 1});
        @(negedge clk);
        manual_step = 1'b0;
        chk("step_fetch_pc", sif.pc, 1);
        chk("step_unpaused", sif.paused, 0);
        chk("step_fetch_load", sif.load, 0);
        while (cyc + 1 < k + 7) @(negedge clk);
        chk("pause2_paused", sif.paused, 1);
        k = cyc + 1;
        manual_step = 1'b1;
        done_q.push_back('{k + 2, 8'h34, 2});
        @(negedge clk);
        manual_step = 1'b0;
        wait_drain("step", 100, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
